// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : vga_pkg                                                    |
// | Brief   : Shared timing defaults, display-mode encoding and counter  |
// |           width helper for the VGA paint driver.                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package vga_pkg;

  // 640x480 @ 60 Hz timing.
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  typedef enum logic {
    MODE_FILL   = 1'b0,
    MODE_CURSOR = 1'b1
  } mode_e;

  // Bits needed to count 0..total-1, never less than one.
  function automatic int cnt_width(input int total);
    return (total <= 2) ? 1 : $clog2(total);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : vga_timing_gen                                             |
// | Brief   : Pixel-enable divider, h/v counters, sync/active decode and |
// |           frame_start strobe.                                        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int CLK_DIV  = 2,
  parameter int HW       = cnt_width(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int VW       = cnt_width(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  output logic          pix_en_o,
  output logic [HW-1:0] h_cnt_o,
  output logic [VW-1:0] v_cnt_o,
  output logic          hs_act_o,
  output logic          vs_act_o,
  output logic          active_o,
  output logic          frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic          pix_en;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          h_last, v_last;

  generate
    if (CLK_DIV == 1) begin : g_div_bypass
      assign pix_en = 1'b1;
    end else begin : g_div
      localparam int DW = $clog2(CLK_DIV);
      logic [DW-1:0] div_q, div_d;
      assign pix_en = (div_q == DW'(CLK_DIV - 1));
      assign div_d  = pix_en ? '0 : div_q + 1'b1;
      // Free-running divider; its terminal count is the pixel enable.
      always_ff @(posedge clk_i) begin
        if (!rst_ni) div_q <= '0;
        else         div_q <= div_d;
      end
    end
  endgenerate

  assign h_last = (h_cnt_q == HW'(H_TOTAL - 1));
  assign v_last = (v_cnt_q == VW'(V_TOTAL - 1));

  // Raster scan: advance one pixel per enable, wrapping line and frame.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_en) begin
      if (h_last) begin
        h_cnt_d = '0;
        v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  // Counter state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign pix_en_o      = pix_en;
  assign h_cnt_o       = h_cnt_q;
  assign v_cnt_o       = v_cnt_q;
  assign hs_act_o      = (h_cnt_q >= HW'(H_ACTIVE + H_FP)) &&
                         (h_cnt_q <= HW'(H_ACTIVE + H_FP + H_SYNC - 1));
  assign vs_act_o      = (v_cnt_q >= VW'(V_ACTIVE + V_FP)) &&
                         (v_cnt_q <= VW'(V_ACTIVE + V_FP + V_SYNC - 1));
  assign active_o      = (h_cnt_q < HW'(H_ACTIVE)) && (v_cnt_q < VW'(V_ACTIVE));
  // Strobe covers the enable cycle in which both counters wrap.
  assign frame_start_o = pix_en && h_last && v_last;

endmodule
`default_nettype wire

// File: rtl/vga_paint_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : vga_paint_driver                                           |
// | Brief   : VGA timing plus solid-fill / movable-cursor painter driven |
// |           by board buttons.                                          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module vga_paint_driver
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = 2,
  parameter int COLOR_W  = 1,
  parameter int BOX_SIZE = 32,
  parameter int STEP     = 8
) (
  input  logic               sysclk,
  input  logic               rst_n,
  input  logic               change_button,
  input  logic               set,
  input  logic [COLOR_W-1:0] R,
  input  logic [COLOR_W-1:0] G,
  input  logic [COLOR_W-1:0] B,
  input  logic               North,
  input  logic               South,
  input  logic               East,
  input  logic               West,
  output logic [COLOR_W-1:0] VGA_R,
  output logic [COLOR_W-1:0] VGA_G,
  output logic [COLOR_W-1:0] VGA_B,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               mode,
  output logic               frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = cnt_width(H_TOTAL);
  localparam int VW      = cnt_width(V_TOTAL);
  // One extra sign bit so a move below zero is seen as negative.
  localparam int XW      = HW + 1;
  localparam int YW      = VW + 1;
  localparam int CW      = 3 * COLOR_W;

  localparam logic signed [XW-1:0] X_MAX  = XW'(H_ACTIVE - BOX_SIZE);
  localparam logic signed [YW-1:0] Y_MAX  = YW'(V_ACTIVE - BOX_SIZE);
  localparam logic signed [XW-1:0] X_INIT = XW'((H_ACTIVE - BOX_SIZE) / 2);
  localparam logic signed [YW-1:0] Y_INIT = YW'((V_ACTIVE - BOX_SIZE) / 2);
  localparam logic signed [XW-1:0] BOX_X  = XW'(BOX_SIZE);
  localparam logic signed [YW-1:0] BOX_Y  = YW'(BOX_SIZE);
  localparam logic signed [XW-1:0] STEP_X = XW'(STEP);
  localparam logic signed [YW-1:0] STEP_Y = YW'(STEP);

  // Button bit positions; bits 0..4 double as pending-flag positions.
  localparam int B_W = 0, B_E = 1, B_S = 2, B_N = 3, B_TGL = 4, B_SET = 5;

  logic          pix_en, hs_act, vs_act, active;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .CLK_DIV  (CLK_DIV),  .HW   (HW),   .VW     (VW)
  ) u_timing (
    .clk_i         (sysclk),
    .rst_ni        (rst_n),
    .pix_en_o      (pix_en),
    .h_cnt_o       (h_cnt),
    .v_cnt_o       (v_cnt),
    .hs_act_o      (hs_act),
    .vs_act_o      (vs_act),
    .active_o      (active),
    .frame_start_o (frame_start)
  );

  logic [5:0]            btn_now, btn_hist_q, btn_evt;
  logic [4:0]            pend_q, pend_d;
  logic [CW-1:0]         colour_q, colour_d;
  mode_e                 mode_q, mode_d;
  logic signed [XW-1:0]  x_q, x_d, x_sum, x_clamp, h_s;
  logic signed [YW-1:0]  y_q, y_d, y_sum, y_clamp, v_s;
  logic                  in_box;
  logic [CW-1:0]         pix_rgb, rgb_q;
  logic                  hs_q, vs_q;

  assign btn_now  = {set, change_button, North, South, East, West};
  assign btn_evt  = btn_now & ~btn_hist_q;
  assign colour_d = btn_evt[B_SET] ? {R, G, B} : colour_q;

  // Candidate cursor position from the pending moves; opposites cancel.
  always_comb begin
    x_sum = x_q;
    y_sum = y_q;
    if (pend_q[B_E] && !pend_q[B_W]) x_sum = x_q + STEP_X;
    else if (pend_q[B_W] && !pend_q[B_E]) x_sum = x_q - STEP_X;
    if (pend_q[B_S] && !pend_q[B_N]) y_sum = y_q + STEP_Y;
    else if (pend_q[B_N] && !pend_q[B_S]) y_sum = y_q - STEP_Y;
    x_clamp = x_sum;
    y_clamp = y_sum;
    if (x_sum[XW-1])        x_clamp = '0;
    else if (x_sum > X_MAX) x_clamp = X_MAX;
    if (y_sum[YW-1])        y_clamp = '0;
    else if (y_sum > Y_MAX) y_clamp = Y_MAX;
  end

  // Frame-boundary commit: toggle first, then moves only in cursor mode.
  always_comb begin
    pend_d = pend_q | btn_evt[4:0];
    mode_d = mode_q;
    x_d    = x_q;
    y_d    = y_q;
    if (frame_start) begin
      // Edges seen in the boundary cycle itself carry into the next frame.
      pend_d = btn_evt[4:0];
      if (pend_q[B_TGL]) mode_d = (mode_q == MODE_FILL) ? MODE_CURSOR : MODE_FILL;
      if (mode_d == MODE_CURSOR) begin
        x_d = x_clamp;
        y_d = y_clamp;
      end
    end
  end

  // Control state: button history, pending flags, colour, mode, cursor.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      btn_hist_q <= '0;
      pend_q     <= '0;
      colour_q   <= '0;
      mode_q     <= MODE_FILL;
      x_q        <= X_INIT;
      y_q        <= Y_INIT;
    end else begin
      btn_hist_q <= btn_now;
      pend_q     <= pend_d;
      colour_q   <= colour_d;
      mode_q     <= mode_d;
      x_q        <= x_d;
      y_q        <= y_d;
    end
  end

  assign h_s    = {1'b0, h_cnt};
  assign v_s    = {1'b0, v_cnt};
  assign in_box = (h_s >= x_q) && (h_s < x_q + BOX_X) &&
                  (v_s >= y_q) && (v_s < y_q + BOX_Y);

  // Pixel colour for the current counters; blanking forces black.
  always_comb begin
    pix_rgb = '0;
    if (active && ((mode_q == MODE_FILL) || in_box)) pix_rgb = colour_q;
  end

  // Output register: one pixel of latency, colour and syncs aligned.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      rgb_q <= '0;
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
    end else if (pix_en) begin
      rgb_q <= pix_rgb;
      hs_q  <= hs_act ? HS_POL : ~HS_POL;
      vs_q  <= vs_act ? VS_POL : ~VS_POL;
    end
  end

  assign {VGA_R, VGA_G, VGA_B} = rgb_q;
  assign VGA_HS = hs_q;
  assign VGA_VS = vs_q;
  assign mode   = mode_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_paint_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_vga_paint_driver                                        |
// | Brief   : Self-checking bench for vga_paint_driver on a 14x9 raster. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_vga_paint_driver;

  localparam int HA = 8, HFP = 2, HSW = 2, HBP = 2;
  localparam int VA = 6, VFP = 1, VSW = 1, VBP = 1;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int DIV = 2, BOX = 2, STEP = 1;
  localparam int FRAME_PIX = HT * VT;

  logic       sysclk = 1'b0;
  logic       rst_n, change_button, set, North, South, East, West;
  logic [1:0] R, G, B, VGA_R, VGA_G, VGA_B;
  logic       VGA_HS, VGA_VS, mode, frame_start;

  vga_paint_driver #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
    .HS_POL (1'b0), .VS_POL (1'b0), .CLK_DIV (DIV), .COLOR_W (2),
    .BOX_SIZE (BOX), .STEP (STEP)
  ) dut (
    .sysclk (sysclk), .rst_n (rst_n), .change_button (change_button), .set (set),
    .R (R), .G (G), .B (B), .North (North), .South (South), .East (East), .West (West),
    .VGA_R (VGA_R), .VGA_G (VGA_G), .VGA_B (VGA_B), .VGA_HS (VGA_HS), .VGA_VS (VGA_VS),
    .mode (mode), .frame_start (frame_start)
  );

  always #5 sysclk = ~sysclk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pixel index arithmetic plus pending/cursor bookkeeping.
  int         k;          // sysclk edges since reset release
  int         cyc = 0;
  int         last_fs;
  bit         m_mode;
  logic [5:0] m_col;
  int         mx, my;
  bit         p_tgl, p_n, p_s, p_e, p_w;
  bit         pv_set, pv_chg, pv_n, pv_s, pv_e, pv_w;
  logic [1:0] er, eg, eb;
  bit         ehs, evs, exp_fs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int val, input int hi);
    return (val < 0) ? 0 : (val > hi) ? hi : val;
  endfunction

  task automatic m_reset();
    k = 0; last_fs = -1;
    m_mode = 0; m_col = '0;
    mx = (HA - BOX) / 2; my = (VA - BOX) / 2;
    {p_tgl, p_n, p_s, p_e, p_w} = '0;
    {pv_set, pv_chg, pv_n, pv_s, pv_e, pv_w} = '0;
    er = '0; eg = '0; eb = '0; ehs = 1; evs = 1;
  endtask

  function automatic int cur_h(); return (k / DIV) % HT; endfunction
  function automatic int cur_v(); return ((k / DIV) / HT) % VT; endfunction

  // Advance model and DUT one sysclk edge, then compare every output.
  task automatic tick();
    int m, h, v;
    bit pix, fs, e_set, e_chg, e_n, e_s, e_e, e_w;
    if (!rst_n) begin
      m_reset();
    end else begin
      pix = ((k + 1) % DIV) == 0;
      m   = k / DIV;
      h   = m % HT;
      v   = (m / HT) % VT;
      fs  = pix && ((m % FRAME_PIX) == FRAME_PIX - 1);
      e_set = set && !pv_set;          e_chg = change_button && !pv_chg;
      e_n = North && !pv_n; e_s = South && !pv_s;
      e_e = East && !pv_e;  e_w = West && !pv_w;
      if (pix) begin
        if (h < HA && v < VA &&
            (!m_mode || (h >= mx && h < mx + BOX && v >= my && v < my + BOX)))
          {er, eg, eb} = m_col;
        else
          {er, eg, eb} = '0;
        ehs = !(h >= HA + HFP && h < HA + HFP + HSW);
        evs = !(v >= VA + VFP && v < VA + VFP + VSW);
      end
      if (e_set) m_col = {R, G, B};
      if (fs) begin
        if (p_tgl) m_mode = !m_mode;
        if (m_mode) begin
          mx = clampi(mx + (int'(p_e) - int'(p_w)) * STEP, HA - BOX);
          my = clampi(my + (int'(p_s) - int'(p_n)) * STEP, VA - BOX);
        end
        {p_tgl, p_n, p_s, p_e, p_w} = {e_chg, e_n, e_s, e_e, e_w};
      end else begin
        {p_tgl, p_n, p_s, p_e, p_w} = {p_tgl | e_chg, p_n | e_n, p_s | e_s, p_e | e_e, p_w | e_w};
      end
      {pv_set, pv_chg, pv_n, pv_s, pv_e, pv_w} = {set, change_button, North, South, East, West};
      k++;
    end
    @(posedge sysclk);
    #1;
    cyc++;
    exp_fs = (((k + 1) % DIV) == 0) && (((k / DIV) % FRAME_PIX) == FRAME_PIX - 1);
    chk("vga_r", VGA_R, er);
    chk("vga_g", VGA_G, eg);
    chk("vga_b", VGA_B, eb);
    chk("vga_hs", VGA_HS, ehs);
    chk("vga_vs", VGA_VS, evs);
    chk("mode", mode, m_mode);
    chk("frame_start", frame_start, exp_fs);
    if (frame_start === 1'b1) begin
      if (last_fs >= 0) chk("fs_period", cyc - last_fs, 2 * FRAME_PIX);
      last_fs = cyc;
    end
  endtask

  // Stop in the cycle where the DUT raises frame_start.
  task automatic wait_fs_cycle();
    int n = 0;
    while (frame_start !== 1'b1 && n < 600) begin
      tick();
      n++;
    end
    chk("fs_timeout", n < 600, 1);
  endtask

  task automatic wait_boundary();
    wait_fs_cycle();
    tick();
  endtask

  task automatic wait_hv(input int h, input int v);
    int n = 0;
    while (!(cur_h() == h && cur_v() == v) && n < 600) begin
      tick();
      n++;
    end
  endtask

  initial begin
    rst_n = 0; change_button = 0; set = 0;
    North = 0; South = 0; East = 0; West = 0;
    R = '0; G = '0; B = '0;
    m_reset();
    repeat (3) tick();
    chk("rst_h_cnt", dut.u_timing.h_cnt_q, 0);
    chk("rst_v_cnt", dut.u_timing.v_cnt_q, 0);
    chk("rst_x", dut.x_q, 3);
    chk("rst_y", dut.y_q, 2);
    chk("rst_colour", dut.colour_q, 0);
    rst_n = 1;

    // Two plain frames: sync shape, blanking, frame period.
    repeat (2 * 2 * FRAME_PIX + 4) tick();

    // Fill with 3/1/0, then a few random colours at random moments.
    R = 2'd3; G = 2'd1; B = 2'd0;
    set = 1; tick(); set = 0;
    repeat (2 * FRAME_PIX + 10) tick();
    for (int i = 0; i < 4; i++) begin
      R = 2'($urandom_range(0, 3)); G = 2'($urandom_range(0, 3)); B = 2'($urandom_range(0, 3));
      repeat ($urandom_range(1, 80)) tick();
      set = 1; tick(); set = 0;
    end
    R = 2'd3; G = 2'd1; B = 2'd2;
    set = 1; tick(); set = 0;

    // Cursor mode, then two East pulses in one frame move a single step.
    wait_boundary();
    change_button = 1; tick(); change_button = 0;
    wait_boundary();
    chk("cursor_mode", mode, 1);
    chk("cursor_x0", dut.x_q, 3);
    repeat (100) tick();
    East = 1; tick(); East = 0; tick(); East = 1; tick(); East = 0;
    wait_boundary();
    chk("east_x", dut.x_q, 4);
    chk("east_y", dut.y_q, 2);

    // West clamp at zero.
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(5, 150)) tick();
      West = 1; tick(); West = 0;
      wait_boundary();
    end
    chk("clamp_x", dut.x_q, 0);

    // North+South together cancel.
    repeat (50) tick();
    North = 1; South = 1; tick(); North = 0; South = 0;
    wait_boundary();
    chk("cancel_y", dut.y_q, 2);

    // Reset pulse at h=5, v=3.
    wait_hv(5, 3);
    chk("pre_rst_h", dut.u_timing.h_cnt_q, 5);
    rst_n = 0; tick(); rst_n = 1;
    chk("mrst_h_cnt", dut.u_timing.h_cnt_q, 0);
    chk("mrst_v_cnt", dut.u_timing.v_cnt_q, 0);
    chk("mrst_mode", mode, 0);
    chk("mrst_colour", dut.colour_q, 0);
    chk("mrst_hs", VGA_HS, 1);
    chk("mrst_vs", VGA_VS, 1);
    chk("mrst_x", dut.x_q, 3);
    chk("mrst_y", dut.y_q, 2);

    // North edge in the frame_start cycle applies one frame later.
    change_button = 1; tick(); change_button = 0;
    wait_boundary();
    chk("coinc_mode", mode, 1);
    wait_fs_cycle();
    North = 1; tick(); North = 0;
    chk("coinc_y_hold", dut.y_q, 2);
    wait_boundary();
    chk("coinc_y_move", dut.y_q, 1);

    // Random button activity under the reference model.
    for (int c = 0; c < 1600; c++) begin
      if ($urandom_range(0, 29) == 0) North = ~North;
      if ($urandom_range(0, 29) == 0) South = ~South;
      if ($urandom_range(0, 29) == 0) East = ~East;
      if ($urandom_range(0, 29) == 0) West = ~West;
      if ($urandom_range(0, 59) == 0) change_button = ~change_button;
      if ($urandom_range(0, 39) == 0) set = ~set;
      if ($urandom_range(0, 9) == 0) begin
        R = 2'($urandom_range(0, 3)); G = 2'($urandom_range(0, 3)); B = 2'($urandom_range(0, 3));
      end
      tick();
    end
    {North, South, East, West, change_button, set} = '0;
    repeat (2 * FRAME_PIX) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_paint_driver.md
Name: vga_paint_driver

Overview:
Parametrised successor to the single-bit vgadriver. Generates VGA timing from sysclk through a pixel-enable divider with configurable porch, sync and polarity, and drives COLOR_W-bit RGB. Two display modes: solid fill, and a movable cursor box steered by the N/S/E/W buttons. Sits between the board buttons/switches and the VGA connector pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, asserted level of VGA_HS
VS_POL, 0, asserted level of VGA_VS
CLK_DIV, 2, sysclk cycles per pixel (>=1)
COLOR_W, 1, bits per colour channel
BOX_SIZE, 32, cursor box side in pixels (< V_ACTIVE, < H_ACTIVE)
STEP, 8, pixels moved per button press

Ports:
sysclk  in  1  system clock, 50 MHz
rst_n  in  1  synchronous reset, active-low
change_button  in  1  rising edge requests a mode toggle
set  in  1  rising edge latches R/G/B into the colour register
R, G, B  in  COLOR_W each  colour to latch
North, South, East, West  in  1  rising edge requests a cursor move
VGA_R, VGA_G, VGA_B  out  COLOR_W each  pixel colour
VGA_HS, VGA_VS  out  1  sync outputs
mode  out  1  current display mode: 0 = fill, 1 = cursor
frame_start  out  1  one-sysclk pulse at the start of each frame

Behaviour:
- Single clock domain, sysclk. Reset is synchronous, active-low: it is sampled only on the sysclk rising edge.
- Reset state:
  - Divider, h_cnt and v_cnt are 0.
  - mode=0; colour register=0; no pending requests.
  - Cursor at x=(H_ACTIVE-BOX_SIZE)/2, y=(V_ACTIVE-BOX_SIZE)/2.
  - VGA_R/G/B=0, VGA_HS=~HS_POL, VGA_VS=~VS_POL, frame_start=0.
  - Edge-detect history registers=0.
- Reset asserted mid-frame returns everything to the reset state on the next sysclk edge. After release, the first pix_en occurs CLK_DIV cycles later.
- Pixel enable: pix_en is high 1 cycle in CLK_DIV; with CLK_DIV=1 it is constantly high.
- Counters: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is defined the same way.
  - On pix_en, h_cnt increments.
  - When h_cnt=H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - v_cnt wraps to 0 after V_TOTAL-1.
- Sync:
  - HS asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - VS asserted for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
  - The output level is the POL value when asserted, its inverse otherwise.
- Output timing: all VGA outputs are registered on pix_en from the current counters, giving exactly 1 pixel of latency. Colour, HS and VS are mutually aligned.
- Blanking: outside the active area (h_cnt>=H_ACTIVE or v_cnt>=V_ACTIVE), RGB=0.
- Colour in mode 0: the entire active area is the colour register.
- Colour in mode 1: pixels with x<=h_cnt<x+BOX_SIZE and y<=v_cnt<y+BOX_SIZE show the colour register; all other active pixels are 0.
- Edge detection: all button inputs are rising-edge detected on sysclk and need no pix_en. An input held high produces one event only.
- set edge: updates the colour register on the next sysclk edge, effective immediately, so mid-frame tearing is allowed.
- change_button edge: sets a pending-toggle flag. Direction edges set per-direction pending flags. Repeated edges before the frame boundary collapse into one.
- Frame boundary (the pix_en cycle where h_cnt and v_cnt both wrap to 0):
  - frame_start pulses for that one sysclk cycle.
  - A pending toggle inverts mode.
  - Pending moves are applied only when mode=1 (after the toggle takes effect).
  - All pending flags clear.
  - An edge arriving in that same cycle is kept pending for the next frame, not lost.
- Move arithmetic:
  - N: y-=STEP; S: y+=STEP; W: x-=STEP; E: x+=STEP.
  - Opposite pairs pending together (N+S, or E+W) cancel. Orthogonal pairs both apply.
  - Results clamp to x in [0, H_ACTIVE-BOX_SIZE] and y in [0, V_ACTIVE-BOX_SIZE]; there is no wrap-around.
  - Comparisons use widths of clog2(H_TOTAL) and clog2(V_TOTAL) plus one sign/guard bit, so underflow cannot wrap.

Decomposition:
- Package vga_pkg: default timing constants (640x480@60), the mode encoding (MODE_FILL=0, MODE_CURSOR=1), and a clog2-based counter-width function.
- Sub-module vga_timing_gen: divider, h/v counters, sync decode, active flag and frame_start. Parameterised by the timing parameters; instantiated once.
- Edge detection, the pending/cursor logic and the output register stay in vga_paint_driver.

Test Plan:
- Bench setup for all scenarios: small timing of H 8/2/2/2 and V 6/1/1/1, CLK_DIV=2, COLOR_W=2, BOX_SIZE=2, STEP=1.
- Timing: run 2 frames after reset. Expect:
  - HS low for pixels h=10..11 of each 14-pixel line.
  - VS low for lines 7 only of each 9-line frame.
  - frame_start period = 14*9*2 = 252 sysclk.
  - RGB=0 during blanking.
- Fill: R=3, G=1, B=0, pulse set. Expect all active pixels 3/1/0 from the next pixel onward; blanking pixels remain 0.
- Cursor: pulse change_button, then pulse East twice mid-frame. Expect:
  - mode=1 at the next frame_start.
  - Box moves from x=3 to x=4 (one step only) at the following frame boundary, y=2 unchanged.
- Clamp/cancel:
  - 10 frames, each with one West pulse: x saturates at 0.
  - North+South in the same frame: y stays put.
- Reset mid-frame: drop rst_n at h=5, v=3 for 1 sysclk. Expect on the next edge: counters 0, mode=0, colour 0, HS/VS high, cursor back at (3,2).
- Edge coincident with frame boundary: assert North in the frame_start cycle. Expect the move applied at the subsequent frame, not dropped.
